// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter: action encoding,
// request priority resolution and the return-stack count width.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_BR,
      PC_LD,
      PC_CALL,
      PC_RET,
      PC_STALL
   } pc_action_e;

   // Exactly one action per edge: stall > ret > call > ld > br > inc > hold.
   function automatic pc_action_e resolve_action(input logic stall,
                                                 input logic ret,
                                                 input logic call,
                                                 input logic ld,
                                                 input logic br,
                                                 input logic inc);
      if (stall)     return PC_STALL;
      else if (ret)  return PC_RET;
      else if (call) return PC_CALL;
      else if (ld)   return PC_LD;
      else if (br)   return PC_BR;
      else if (inc)  return PC_INC;
      else           return PC_HOLD;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry, a pop when empty changes nothing and only raises unf_evt.
module ras_stack
   import pc_pkg::*;
#(
   parameter int AW        = 16,
   parameter int RAS_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic                            pop,
   input  logic [AW-1:0]                   din,
   output logic [AW-1:0]                   dout,
   output logic [cnt_width(RAS_DEPTH)-1:0] cnt,
   output logic                            full,
   output logic                            empty,
   output logic                            ovf_evt,
   output logic                            unf_evt
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = cnt_width(RAS_DEPTH);

   logic [AW-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0] top_q, top_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] next_ptr, prev_ptr;

   assign next_ptr = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
   assign prev_ptr = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - 1'b1;

   assign full    = (cnt_q == CW'(RAS_DEPTH));
   assign empty   = (cnt_q == '0);
   assign cnt     = cnt_q;
   assign dout    = mem_q[top_q];
   assign ovf_evt = push & full;
   assign unf_evt = pop & empty;

   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      if (push) begin
         top_d = next_ptr;
         if (!full) cnt_d = cnt_q + 1'b1;
      end else if (pop && !empty) begin
         top_d = prev_ptr;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[next_ptr] <= din;
   end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with absolute/relative jumps, stall, and a hardware
// return-address stack for call/return; pc drives the fetch address.
module pc_ras_unit
   import pc_pkg::*;
#(
   parameter int            AW        = 16,
   parameter int            OW        = 8,
   parameter int            RAS_DEPTH = 8,
   parameter logic [AW-1:0] RESET_VEC = '0,
   parameter int            INC_STEP  = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            stall,
   input  logic                            inc,
   input  logic                            ld,
   input  logic                            br,
   input  logic                            call,
   input  logic                            ret,
   input  logic                            clr_err,
   input  logic [AW-1:0]                   tgt,
   input  logic [OW-1:0]                   off,
   output logic [AW-1:0]                   pc,
   output logic [cnt_width(RAS_DEPTH)-1:0] ras_cnt,
   output logic                            ras_full,
   output logic                            ras_empty,
   output logic                            ras_ovf,
   output logic                            ras_unf
);

   pc_action_e    action;
   logic [AW-1:0] pc_q, pc_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic [AW-1:0] off_ext;
   logic [AW-1:0] pc_next_seq;
   logic [AW-1:0] ras_dout;
   logic          ras_push, ras_pop;
   logic          ovf_evt, unf_evt;

   assign action      = resolve_action(stall, ret, call, ld, br, inc);
   assign off_ext     = AW'($signed(off));
   assign pc_next_seq = pc_q + AW'(INC_STEP);
   assign ras_push    = (action == PC_CALL);
   assign ras_pop     = (action == PC_RET);

   ras_stack #(
      .AW        (AW),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push    (ras_push),
      .pop     (ras_pop),
      .din     (pc_next_seq),
      .dout    (ras_dout),
      .cnt     (ras_cnt),
      .full    (ras_full),
      .empty   (ras_empty),
      .ovf_evt (ovf_evt),
      .unf_evt (unf_evt)
   );

   always_comb begin
      pc_d = pc_q;
      case (action)
         PC_RET:   if (!ras_empty) pc_d = ras_dout;
         PC_CALL:  pc_d = tgt;
         PC_LD:    pc_d = tgt;
         PC_BR:    pc_d = pc_q + off_ext;
         PC_INC:   pc_d = pc_next_seq;
         PC_STALL: pc_d = pc_q;
         PC_HOLD:  pc_d = pc_q;
         default:  pc_d = pc_q;
      endcase
   end

   // A new event in the same cycle as clr_err leaves the flag set.
   always_comb begin
      ovf_d = (ovf_q & ~clr_err) | ovf_evt;
      unf_d = (unf_q & ~clr_err) | unf_evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_VEC;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign pc      = pc_q;
   assign ras_ovf = ovf_q;
   assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios plus random
// traffic against a queue-based reference model; second wide instance.
module tb_pc_ras_unit;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, inc, ld, br, call, ret, clr_err;
   logic [15:0] tgt;
   logic [7:0]  off;
   logic [15:0] pc;
   logic [3:0]  ras_cnt;
   logic        ras_full, ras_empty, ras_ovf, ras_unf;

   logic        wStall, wInc, wLd, wBr, wCall, wRet, wClr;
   logic [23:0] wTgt;
   logic [7:0]  wOff;
   logic [23:0] wPc;
   logic [2:0]  wCnt;
   logic        wFull, wEmpty, wOvf, wUnf;

   logic [15:0] pcM;
   logic [15:0] rasM[$];
   logic        ovfM, unfM;
   int          testsRun = 0;
   int          testsFailed = 0;

   always #5 clk = ~clk;

   pc_ras_unit #(.AW(16), .OW(8), .RAS_DEPTH(DEPTH), .RESET_VEC(16'h0000), .INC_STEP(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .inc(inc), .ld(ld), .br(br), .call(call), .ret(ret),
      .clr_err(clr_err), .tgt(tgt), .off(off), .pc(pc), .ras_cnt(ras_cnt), .ras_full(ras_full),
      .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf));

   pc_ras_unit #(.AW(24), .OW(8), .RAS_DEPTH(4), .RESET_VEC(24'h100000), .INC_STEP(2)) dutWide (
      .clk(clk), .rst(rst), .stall(wStall), .inc(wInc), .ld(wLd), .br(wBr), .call(wCall), .ret(wRet),
      .clr_err(wClr), .tgt(wTgt), .off(wOff), .pc(wPc), .ras_cnt(wCnt), .ras_full(wFull),
      .ras_empty(wEmpty), .ras_ovf(wOvf), .ras_unf(wUnf));

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      pcM = 16'h0000;
      rasM.delete();
      ovfM = 1'b0;
      unfM = 1'b0;
   endtask

   // Reference behaviour: oldest entry sits at the queue front.
   task automatic modelStep();
      logic ovfE, unfE;
      ovfE = 1'b0;
      unfE = 1'b0;
      if (!stall) begin
         if (ret) begin
            if (rasM.size() > 0) pcM = rasM.pop_back();
            else unfE = 1'b1;
         end else if (call) begin
            if (rasM.size() == DEPTH) begin
               void'(rasM.pop_front());
               ovfE = 1'b1;
            end
            rasM.push_back(pcM + 16'd1);
            pcM = tgt;
         end else if (ld) pcM = tgt;
         else if (br) pcM = pcM + {{8{off[7]}}, off};
         else if (inc) pcM = pcM + 16'd1;
      end
      if (clr_err) begin
         ovfM = 1'b0;
         unfM = 1'b0;
      end
      ovfM = ovfM | ovfE;
      unfM = unfM | unfE;
   endtask

   task automatic applyStimulus(input logic s, input logic i, input logic l, input logic b,
                                input logic c, input logic r, input logic ce,
                                input logic [15:0] t, input logic [7:0] o);
      stall = s; inc = i; ld = l; br = b; call = c; ret = r; clr_err = ce; tgt = t; off = o;
      modelStep();
      @(posedge clk);
      #1;
      stall = 0; inc = 0; ld = 0; br = 0; call = 0; ret = 0; clr_err = 0;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".pc"}, 32'(pc), 32'(pcM));
      checkOutput({tag, ".cnt"}, 32'(ras_cnt), 32'(rasM.size()));
      checkOutput({tag, ".full"}, 32'(ras_full), 32'(rasM.size() == DEPTH));
      checkOutput({tag, ".empty"}, 32'(ras_empty), 32'(rasM.size() == 0));
      checkOutput({tag, ".ovf"}, 32'(ras_ovf), 32'(ovfM));
      checkOutput({tag, ".unf"}, 32'(ras_unf), 32'(unfM));
   endtask

   task automatic wideStep(input logic i, input logic l, input logic b, input logic c,
                           input logic r, input logic [23:0] t, input logic [7:0] o);
      wInc = i; wLd = l; wBr = b; wCall = c; wRet = r; wTgt = t; wOff = o;
      @(posedge clk);
      #1;
      wInc = 0; wLd = 0; wBr = 0; wCall = 0; wRet = 0;
   endtask

   initial begin
      rst = 1'b1;
      stall = 0; inc = 0; ld = 0; br = 0; call = 0; ret = 0; clr_err = 0; tgt = '0; off = '0;
      wStall = 0; wInc = 0; wLd = 0; wBr = 0; wCall = 0; wRet = 0; wClr = 0; wTgt = '0; wOff = '0;
      modelReset();
      #12;
      checkAll("reset");
      checkOutput("wide.reset", 32'(wPc), 32'h100000);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int k = 1; k <= 4; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
         checkOutput("inc.seq", 32'(pc), 32'(k));
      end
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hFFFF, 8'h0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
      checkOutput("inc.wrap", 32'(pc), 32'h0000);
      checkAll("inc.wrap");

      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'h0010, 8'h0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h0, 8'hFC);
      checkOutput("br.neg", 32'(pc), 32'h000C);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h0, 8'h7F);
      checkOutput("br.pos", 32'(pc), 32'h008B);
      applyStimulus(0, 1, 1, 1, 0, 0, 0, 16'h1234, 8'h05);
      checkOutput("ld.prio", 32'(pc), 32'h1234);

      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'h0100, 8'h0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'h0200, 8'h0);
      checkOutput("call1.pc", 32'(pc), 32'h0200);
      checkOutput("call1.cnt", 32'(ras_cnt), 32'd1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'h0300, 8'h0);
      checkOutput("call2.cnt", 32'(ras_cnt), 32'd2);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
      checkOutput("ret1.pc", 32'(pc), 32'h0201);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
      checkOutput("ret2.pc", 32'(pc), 32'h0101);
      checkOutput("ret2.empty", 32'(ras_empty), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
      checkOutput("ret3.pc", 32'(pc), 32'h0101);
      checkOutput("ret3.unf", 32'(ras_unf), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);
      checkOutput("clr.unf", 32'(ras_unf), 32'd0);

      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'h0000, 8'h0);
      for (int k = 1; k <= 9; k++)
         applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'(k * 16), 8'h0);
      checkOutput("ovf.full", 32'(ras_full), 32'd1);
      checkOutput("ovf.flag", 32'(ras_ovf), 32'd1);
      checkOutput("ovf.cnt", 32'(ras_cnt), 32'd8);
      for (int k = 8; k >= 1; k--) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
         checkOutput("ovf.retseq", 32'(pc), 32'(k * 16 + 1));
      end
      checkOutput("ovf.empty", 32'(ras_empty), 32'd1);
      checkAll("ovf.end");

      applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'h0500, 8'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'h0700, 8'h0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, k[0], 0, 0, ~k[0], k[1], 0, 16'h0999, 8'h0);
         checkAll("stall");
      end
      applyStimulus(1, 1, 0, 0, 0, 1, 1, 16'h0, 8'h0);
      checkOutput("stall.clr.ovf", 32'(ras_ovf), 32'd0);
      checkOutput("stall.clr.unf", 32'(ras_unf), 32'd0);
      checkOutput("stall.clr.pc", 32'(pc), 32'h0700);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 16'h0, 8'h0);
      checkOutput("clr.vs.unf", 32'(ras_unf), 32'd1);
      checkAll("clr.vs.unf");

      for (int k = 0; k < 3; k++)
         applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'(16'h0040 + k), 8'h0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'h0456, 8'h0);
      checkOutput("pre.async.cnt", 32'(ras_cnt), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkAll("async.rst");
      #3;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(7) == 0, $urandom_range(1) == 0, $urandom_range(7) == 0,
                       $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                       $urandom_range(7) == 0, 16'($urandom), 8'($urandom));
         checkAll("rand");
      end

      wideStep(1, 0, 0, 0, 0, 24'h0, 8'h0);
      checkOutput("wide.inc", 32'(wPc), 32'h100002);
      wideStep(0, 0, 1, 0, 0, 24'h0, 8'hFC);
      checkOutput("wide.br", 32'(wPc), 32'h0FFFFE);
      wideStep(0, 0, 0, 1, 0, 24'hABCDEF, 8'h0);
      checkOutput("wide.call", 32'(wPc), 32'hABCDEF);
      checkOutput("wide.cnt", 32'(wCnt), 32'd1);
      wideStep(0, 0, 0, 0, 1, 24'h0, 8'h0);
      checkOutput("wide.ret", 32'(wPc), 32'h100000);
      wideStep(0, 1, 0, 0, 0, 24'hFFFFFF, 8'h0);
      wideStep(1, 0, 0, 0, 0, 24'h0, 8'h0);
      checkOutput("wide.wrap", 32'(wPc), 32'h000001);
      checkOutput("wide.flags", 32'({wOvf, wUnf}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised program counter for the 16-bit RISC CPU and its wider-address successors.
- Supports absolute load, signed relative branch, configurable increment step, pipeline stall, and a hardware return-address stack (RAS) for call/return.
- Sits between the control unit and instruction memory; `pc` drives the instruction address bus directly.

Parameters:
- AW, 16: PC and address width in bits.
- OW, 8: width of the signed relative-branch offset; must satisfy OW <= AW.
- RAS_DEPTH, 8: number of return-address entries; must be >= 2.
- RESET_VEC, 0: PC value loaded on reset; AW bits.
- INC_STEP, 1: amount added on increment and used for the call return address.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- stall, input, 1: freezes all state, including PC and RAS.
- inc, input, 1: advance PC by INC_STEP.
- ld, input, 1: absolute jump, PC <= tgt.
- br, input, 1: relative branch, PC <= PC + sign-extended off.
- call, input, 1: push return address, then PC <= tgt.
- ret, input, 1: PC <= top of RAS, then pop.
- clr_err, input, 1: clears the sticky error flags.
- tgt, input, AW: target address for ld/call.
- off, input, OW: two's-complement branch offset.
- pc, output, AW: current program counter.
- ras_cnt, output, clog2(RAS_DEPTH+1): number of valid RAS entries.
- ras_full, output, 1: ras_cnt == RAS_DEPTH.
- ras_empty, output, 1: ras_cnt == 0.
- ras_ovf, output, 1: sticky; a call occurred while the RAS was full.
- ras_unf, output, 1: sticky; a ret occurred while the RAS was empty.

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc = RESET_VEC, ras_cnt = 0, ras_ovf = 0, ras_unf = 0.
  - RAS storage contents are don't-care.
  - Reset overrides every other input.
- Per-edge priority, exactly one action per cycle: stall > ret > call > ld > br > inc > hold.
  - Lower-priority requests asserted in the same cycle are ignored, not queued.
- stall=1: pc, RAS, ras_cnt and flags all hold.
  - Exception: clr_err still clears flags when stall=1.
- ret:
  - Non-empty RAS: pc <= RAS[top], ras_cnt decrements.
  - Empty RAS: pc holds, ras_cnt stays 0, ras_unf <= 1.
- call:
  - Pushes (pc + INC_STEP) mod 2^AW and sets pc <= tgt.
  - If the RAS is full: the oldest entry is overwritten (circular buffer), ras_cnt stays at RAS_DEPTH, ras_ovf <= 1.
- ld: pc <= tgt; RAS unchanged.
- br: pc <= (pc + sign_extend(off)) mod 2^AW; off is sign-extended from OW to AW bits. Negative offsets go backwards.
- inc: pc <= (pc + INC_STEP) mod 2^AW. Wrap from 2^AW-1 to 0 is silent; no flag.
- No request asserted: pc holds.
- Flag updates:
  - clr_err=1 clears ras_ovf and ras_unf.
  - If a new overflow/underflow event occurs in the same cycle as clr_err, the set wins and the flag reads 1 afterwards.
- Outputs:
  - All outputs are registered or derived from registers only; no combinational input-to-output path.
  - Latency is one cycle: a request sampled at edge N is visible on pc after edge N.
- RAS implementation:
  - Circular LIFO with a top pointer of width clog2(RAS_DEPTH), which wraps modulo RAS_DEPTH.
  - Push writes at top+1, then advances top. Pop reads at top, then retreats top.
  - Push and pop never occur together, since ret has priority over call.

Decomposition:
- Package pc_pkg:
  - Action encoding enum: PC_HOLD, PC_INC, PC_BR, PC_LD, PC_CALL, PC_RET, PC_STALL.
  - Priority resolver function mapping the request bits to that enum.
  - Width helper for ras_cnt.
- Sub-module ras_stack:
  - Parametrised by AW and RAS_DEPTH.
  - Ports: push, pop, din, dout, cnt, full, empty, ovf_evt, unf_evt.
  - Owns the storage, pointer wrap and overflow-overwrite policy.
- Top level holds the PC register, the adder/sign-extension, and the sticky flags.

Test Plan (defaults unless stated):
1. Reset, then inc held for 4 cycles → pc = 0,1,2,3,4. Then with pc forced to 0xFFFF via ld tgt=0xFFFF, one inc → pc = 0x0000 and no flag set.
2. pc=0x0010; br off=0xFC (-4) → pc = 0x000C. Then br off=0x7F → pc = 0x008B. Then ld, br and inc asserted together with tgt=0x1234 → pc = 0x1234 (ld wins).
3. pc=0x0100; call tgt=0x0200 → pc=0x0200, ras_cnt=1. Next call tgt=0x0300 → ras_cnt=2. ret → pc=0x0201. ret → pc=0x0101, ras_empty=1. ret again → pc holds at 0x0101, ras_unf=1. clr_err → ras_unf=0.
4. With RAS_DEPTH=8, issue 9 calls from pc=0x0000 with tgt=0x0010,0x0020,…,0x0090 → ras_full=1, ras_ovf=1, ras_cnt=8. Then 8 rets → pc sequence 0x0081, 0x0071, …, 0x0011 (the 0x0001 entry is lost), and ras_empty=1.
5. stall=1 for 3 cycles while inc, call and ret toggle → pc and ras_cnt are unchanged throughout. clr_err during stall → flags clear. Then clr_err and a ret on empty in the same cycle → ras_unf=1.
6. Assert rst asynchronously between edges with ras_cnt=3 and pc=0x0456 → pc=RESET_VEC, ras_cnt=0 and flags cleared immediately, before the next clk edge. A second configuration with AW=24, RESET_VEC=0x100000, INC_STEP=2 → pc follows the same rules at the wider width.
